// File: rtl/dram_seq_pkg.sv
// dram_seq_pkg
//   Shared definitions for the DRAM address sequencer:
//   - state encoding localparams and the state_t enum built from them
//   - strobe_t, the bundle of registered DRAM/mux strobes, and its reset value
//   - strobe_for(), the per-state strobe decode. The top registers its result
//     for the *next* state, which keeps every output a flop.
package dram_seq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ROW     = 3'd1;
  localparam logic [2:0] ST_RAS     = 3'd2;
  localparam logic [2:0] ST_COL     = 3'd3;
  localparam logic [2:0] ST_CAS     = 3'd4;
  localparam logic [2:0] ST_PRE     = 3'd5;
  localparam logic [2:0] ST_REF_CAS = 3'd6;
  localparam logic [2:0] ST_REF_RAS = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ROW     = ST_ROW,
    S_RAS     = ST_RAS,
    S_COL     = ST_COL,
    S_CAS     = ST_CAS,
    S_PRE     = ST_PRE,
    S_REF_CAS = ST_REF_CAS,
    S_REF_RAS = ST_REF_RAS
  } state_t;

  typedef struct packed {
    logic ras_n;
    logic cas_n;
    logic we_n;
    logic mux_sel;
    logic mux_oe_n;
  } strobe_t;

  localparam strobe_t STROBE_RST = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                                     mux_sel: 1'b0, mux_oe_n: 1'b1};

  // IDLE and PRE share the reset pattern; everything else departs from it.
  function automatic strobe_t strobe_for(input state_t s, input logic we_l);
    strobe_t o;
    o = STROBE_RST;
    case (s)
      S_ROW: o.mux_oe_n = 1'b0;
      S_RAS: begin
        o.mux_oe_n = 1'b0;
        o.ras_n    = 1'b0;
      end
      S_COL: begin
        o.mux_oe_n = 1'b0;
        o.ras_n    = 1'b0;
        o.mux_sel  = 1'b1;
        o.we_n     = ~we_l;
      end
      S_CAS: begin
        o.mux_oe_n = 1'b0;
        o.ras_n    = 1'b0;
        o.cas_n    = 1'b0;
        o.mux_sel  = 1'b1;
        o.we_n     = ~we_l;
      end
      // CAS-before-RAS: the muxes stay tri-stated, no address is needed.
      S_REF_CAS: o.cas_n = 1'b0;
      S_REF_RAS: begin
        o.ras_n = 1'b0;
        o.cas_n = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer
//   Free-running refresh down-counter plus sticky pending flag.
//   Only instantiated when DRAM_REFRESH_EN is defined.
// Ports:
//   clk      in   system clock
//   reset_n  in   async active-low reset (reloads counter, clears pending)
//   take     in   sequencer is entering REF_CAS this cycle
//   pending  out  refresh owed to the DRAM
module dram_refresh_timer #(
  parameter int REFRESH_PERIOD = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic take,
  output logic pending
);

  localparam int CW = $clog2(REFRESH_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          w_expire;

  // The counter holds 0 for one cycle and reloads on the following edge,
  // so expiries are exactly REFRESH_PERIOD clocks apart.
  assign w_expire = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b0;
    end else begin
      r_cnt     <= w_expire ? RELOAD : r_cnt - 1'b1;
      // A fresh expiry beats a take in the same cycle; a second expiry while
      // already pending collapses into the one flag.
      r_pending <= w_expire | (r_pending & ~take);
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/dram_addr_seq.sv
// dram_addr_seq
//   Drives RAS/CAS/WE and the '257 address mux select/enable for one DRAM
//   bank: row address (mux A), then column address (mux B), then precharge.
//   With DRAM_REFRESH_EN defined, CAS-before-RAS refresh is arbitrated
//   against CPU accesses (refresh wins in IDLE); otherwise refresh_busy is 0.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req, we               CPU request (level, held until ack) and write flag
//   ack                   one-cycle pulse in the last CAS cycle
//   ras_n, cas_n, we_n    DRAM strobes
//   mux_sel, mux_oe_n     address mux select (0=row) and enable (low active)
//   refresh_busy          high during REF_CAS/REF_RAS
module dram_addr_seq
  import dram_seq_pkg::*;
#(
  parameter int RAS_TO_MUX     = 1,
  parameter int CAS_CYC        = 2,
  parameter int RAS_PRE_CYC    = 2,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic we,
  output logic ack,
  output logic ras_n,
  output logic cas_n,
  output logic we_n,
  output logic mux_sel,
  output logic mux_oe_n,
  output logic refresh_busy
);

  if (RAS_TO_MUX < 1 || CAS_CYC < 1 || RAS_PRE_CYC < 1 || REFRESH_PERIOD < 8) begin : g_bad_cfg
    $error("dram_addr_seq: illegal timing parameters");
  end

  // One shared down-counter times every multi-cycle state; REF_RAS is the
  // longest unless precharge is longer.
  localparam int CNT_MAX = ((RAS_TO_MUX + CAS_CYC) > RAS_PRE_CYC) ?
                           (RAS_TO_MUX + CAS_CYC) : RAS_PRE_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] LD_RAS = CW'(RAS_TO_MUX - 1);
  localparam logic [CW-1:0] LD_CAS = CW'(CAS_CYC - 1);
  localparam logic [CW-1:0] LD_PRE = CW'(RAS_PRE_CYC - 1);

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_we;
  logic          w_accept;
  logic          w_ack_nxt;
  strobe_t       r_strobe;
  logic          r_ack;

`ifdef DRAM_REFRESH_EN
  localparam logic [CW-1:0] LD_REF = CW'(RAS_TO_MUX + CAS_CYC - 1);

  logic w_pending;
  logic w_take;
  logic r_ref_busy;

  dram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_ref_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .take    (w_take),
    .pending (w_pending)
  );
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
`ifdef DRAM_REFRESH_EN
    w_take    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef DRAM_REFRESH_EN
        if (w_pending) begin
          w_nxt  = S_REF_CAS;
          w_take = 1'b1;
        end else
`endif
        if (req) begin
          w_nxt    = S_ROW;
          w_accept = 1'b1;
        end
      end
      S_ROW: begin
        w_nxt     = S_RAS;
        w_cnt_nxt = LD_RAS;
      end
      S_RAS: begin
        if (r_cnt == '0) w_nxt = S_COL;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      S_COL: begin
        w_nxt     = S_CAS;
        w_cnt_nxt = LD_CAS;
      end
      S_CAS: begin
        if (r_cnt == '0) begin
          w_nxt     = S_PRE;
          w_cnt_nxt = LD_PRE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_PRE: begin
        if (r_cnt == '0) w_nxt = S_IDLE;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
`ifdef DRAM_REFRESH_EN
      S_REF_CAS: begin
        w_nxt     = S_REF_RAS;
        w_cnt_nxt = LD_REF;
      end
      S_REF_RAS: begin
        if (r_cnt == '0) begin
          w_nxt     = S_PRE;
          w_cnt_nxt = LD_PRE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  assign w_ack_nxt = (w_nxt == S_CAS) && (w_cnt_nxt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_strobe <= STROBE_RST;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= strobe_for(w_nxt, r_we);
      r_ack    <= w_ack_nxt;
      if (w_accept) r_we <= we;
    end
  end

`ifdef DRAM_REFRESH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ref_busy <= 1'b0;
    else          r_ref_busy <= (w_nxt == S_REF_CAS) || (w_nxt == S_REF_RAS);
  end
  assign refresh_busy = r_ref_busy;
`else
  assign refresh_busy = 1'b0;
`endif

  assign ack      = r_ack;
  assign ras_n    = r_strobe.ras_n;
  assign cas_n    = r_strobe.cas_n;
  assign we_n     = r_strobe.we_n;
  assign mux_sel  = r_strobe.mux_sel;
  assign mux_oe_n = r_strobe.mux_oe_n;

endmodule
